// File: rtl/dpram_rdout_streamer.sv
// Streams a filled double_buffer DPRAM page (64-bit read port) out as 16-bit
// valid/ready halfwords, lowest halfword first, then pulses done to release it.
module dpram_rdout_streamer #(
  parameter int P_ADR_WIDTH = 9,
  parameter int P_LEN_WIDTH = 16,
  parameter int P_RD_LAT    = 1,
  parameter int P_HOLDOFF   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   rd_busy,
  input  logic [P_LEN_WIDTH-1:0] dpram_len,
  output logic [P_ADR_WIDTH-1:0] rd_addr,
  input  logic [63:0]            rd_dout,
  output logic                   done,
  output logic [15:0]            m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic [31:0]            n_bufs,
  output logic                   len_err
);

  typedef enum logic [2:0] {IDLE, FETCH, STREAM, FINISH, HOLD} state_t;

  localparam int CW = P_ADR_WIDTH + 1;
  localparam int HW = (P_HOLDOFF > 1) ? $clog2(P_HOLDOFF) : 1;
  localparam logic [P_LEN_WIDTH:0] MAX_L = (P_LEN_WIDTH+1)'(4 << P_ADR_WIDTH);

  state_t                 state_reg, state_next;
  logic [P_LEN_WIDTH-1:0] len_reg;
  logic [P_LEN_WIDTH-1:0] out_cnt_reg;
  logic [CW-1:0]          n_words_reg;
  logic [CW-1:0]          req_cnt_reg;
  logic [P_RD_LAT:0]      pipe_reg;
  logic [63:0]            hold_data_reg, pre_data_reg;
  logic                   hold_valid_reg, pre_valid_reg;
  logic [HW-1:0]          hold_cnt_reg;

  logic                   start, clamp, landing, xfer, hold_done, issue, req_fire;
  logic [P_LEN_WIDTH-1:0] len_start;
  logic [CW-1:0]          n_words_start;
  logic [2:0]             occ;
  logic [15:0]            halves [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_half
      assign halves[gi] = hold_data_reg[16*gi +: 16];
    end
  endgenerate

  assign start         = (state_reg == IDLE) && rd_busy && en;
  assign clamp         = {1'b0, dpram_len} > MAX_L;
  assign len_start     = clamp ? MAX_L[P_LEN_WIDTH-1:0] : dpram_len;
  assign n_words_start = len_start[P_ADR_WIDTH+2:2] + CW'(|len_start[1:0]);
  assign landing       = pipe_reg[P_RD_LAT];
  assign xfer          = hold_valid_reg && m_ready;
  assign hold_done     = xfer && ((out_cnt_reg[1:0] == 2'd3) || m_last);

  // Everything requested but not yet emitted: in-flight reads plus both registers.
  // Counting a word freed this cycle keeps the prefetch early enough for P_RD_LAT=3.
  always_comb begin
    occ = {2'b0, hold_valid_reg} + {2'b0, pre_valid_reg};
    for (int i = 0; i <= P_RD_LAT; i++) begin
      occ = occ + {2'b0, pipe_reg[i]};
    end
  end

  assign issue    = ((state_reg == FETCH) || (state_reg == STREAM)) &&
                    (req_cnt_reg < n_words_reg) && (occ < (3'd2 + {2'b0, hold_done}));
  assign req_fire = issue || (start && (len_start != '0));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (len_start == '0) ? FINISH : FETCH;
      FETCH:   if (landing) state_next = STREAM;
      STREAM:  if (hold_done && m_last) state_next = FINISH;
      FINISH:  state_next = (P_HOLDOFF == 0) ? IDLE : HOLD;
      HOLD:    if (hold_cnt_reg == HW'(P_HOLDOFF - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done    = (state_reg == FINISH);
    m_valid = hold_valid_reg;
    m_data  = halves[out_cnt_reg[1:0]];
    m_last  = hold_valid_reg && (out_cnt_reg == len_reg - P_LEN_WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr        <= '0;
      len_reg        <= '0;
      out_cnt_reg    <= '0;
      n_words_reg    <= '0;
      req_cnt_reg    <= '0;
      pipe_reg       <= '0;
      hold_data_reg  <= '0;
      pre_data_reg   <= '0;
      hold_valid_reg <= 1'b0;
      pre_valid_reg  <= 1'b0;
      hold_cnt_reg   <= '0;
      n_bufs         <= '0;
      len_err        <= 1'b0;
    end else begin
      pipe_reg <= {pipe_reg[P_RD_LAT-1:0], req_fire};
      if (start) begin
        len_reg     <= len_start;
        n_words_reg <= n_words_start;
        out_cnt_reg <= '0;
        rd_addr     <= '0;
        req_cnt_reg <= (len_start != '0) ? CW'(1) : '0;
        if (clamp) len_err <= 1'b1;
      end else begin
        if (issue) begin
          rd_addr     <= req_cnt_reg[P_ADR_WIDTH-1:0];
          req_cnt_reg <= req_cnt_reg + CW'(1);
        end
        if (xfer) out_cnt_reg <= out_cnt_reg + P_LEN_WIDTH'(1);
      end
      // Landing data goes straight to the holding register when it frees up.
      if (!hold_valid_reg || hold_done) begin
        if (pre_valid_reg) begin
          hold_data_reg  <= pre_data_reg;
          hold_valid_reg <= 1'b1;
          pre_valid_reg  <= landing;
          if (landing) pre_data_reg <= rd_dout;
        end else begin
          hold_valid_reg <= landing;
          if (landing) hold_data_reg <= rd_dout;
        end
      end else if (landing) begin
        pre_data_reg  <= rd_dout;
        pre_valid_reg <= 1'b1;
      end
      hold_cnt_reg <= (state_reg == HOLD) ? hold_cnt_reg + HW'(1) : '0;
      if (state_reg == FINISH) n_bufs <= n_bufs + 32'd1;
    end
  end

endmodule

// File: tb/tb_dpram_rdout_streamer.sv
// Directed bench: two streamer instances (read latency 1 and 3) each fed by a
// DPRAM model whose halfword i holds value i.
module tb_dpram_rdout_streamer;
  localparam int HOLDOFF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, m_ready, busy_1, busy_3;
  logic [15:0] dpram_len;
  logic [8:0]  rd_addr_1, rd_addr_3;
  logic [63:0] rd_dout_1, rd_dout_3;
  logic        done_1, done_3, m_valid_1, m_valid_3, m_last_1, m_last_3, len_err_1, len_err_3;
  logic [15:0] m_data_1, m_data_3;
  logic [31:0] n_bufs_1, n_bufs_3;

  dpram_rdout_streamer #(.P_RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .en(en), .rd_busy(busy_1), .dpram_len(dpram_len),
    .rd_addr(rd_addr_1), .rd_dout(rd_dout_1), .done(done_1), .m_data(m_data_1),
    .m_valid(m_valid_1), .m_last(m_last_1), .m_ready(m_ready), .n_bufs(n_bufs_1),
    .len_err(len_err_1));

  dpram_rdout_streamer #(.P_RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .en(en), .rd_busy(busy_3), .dpram_len(dpram_len),
    .rd_addr(rd_addr_3), .rd_dout(rd_dout_3), .done(done_3), .m_data(m_data_3),
    .m_valid(m_valid_3), .m_last(m_last_3), .m_ready(m_ready), .n_bufs(n_bufs_3),
    .len_err(len_err_3));

  function automatic logic [63:0] mem_word(input logic [8:0] a);
    logic [15:0] b;
    b = {5'd0, a, 2'b00};
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  logic [8:0] ap1;
  logic [8:0] ap3 [3];
  always @(posedge clk) begin
    ap1    <= rd_addr_1;
    ap3[0] <= rd_addr_3;
    ap3[1] <= ap3[0];
    ap3[2] <= ap3[1];
  end
  assign rd_dout_1 = mem_word(ap1);
  assign rd_dout_3 = mem_word(ap3[2]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic last; logic [15:0] data; int cyc;} beat_t;
  beat_t q_1[$];
  beat_t q_3[$];
  int done_cnt_1 = 0, done_cyc_1 = 0, stall_err_1 = 0, addr2_hits_1 = 0;
  int done_cnt_3 = 0, done_cyc_3 = 0, stall_err_3 = 0;
  logic prev_stall_1 = 1'b0, prev_last_1 = 1'b0, prev_stall_3 = 1'b0, prev_last_3 = 1'b0;
  logic [15:0] prev_data_1 = '0, prev_data_3 = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall_1 <= 1'b0;
    end else begin
      if (m_valid_1 && m_ready) q_1.push_back('{m_last_1, m_data_1, cyc});
      if (prev_stall_1 && (!m_valid_1 || m_data_1 !== prev_data_1 || m_last_1 !== prev_last_1))
        stall_err_1 <= stall_err_1 + 1;
      prev_stall_1 <= m_valid_1 && !m_ready;
      prev_data_1  <= m_data_1;
      prev_last_1  <= m_last_1;
      if (done_1) begin done_cnt_1 <= done_cnt_1 + 1; done_cyc_1 <= cyc; end
      if (rd_addr_1 == 9'd2) addr2_hits_1 <= addr2_hits_1 + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall_3 <= 1'b0;
    end else begin
      if (m_valid_3 && m_ready) q_3.push_back('{m_last_3, m_data_3, cyc});
      if (prev_stall_3 && (!m_valid_3 || m_data_3 !== prev_data_3 || m_last_3 !== prev_last_3))
        stall_err_3 <= stall_err_3 + 1;
      prev_stall_3 <= m_valid_3 && !m_ready;
      prev_data_3  <= m_data_3;
      prev_last_3  <= m_last_3;
      if (done_3) begin done_cnt_3 <= done_cnt_3 + 1; done_cyc_3 <= cyc; end
    end
  end

  logic [31:0] ready_pat = 32'hB2E5_3A69;
  bit          ready_mode = 1'b0;
  int          rk = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = ready_mode ? ready_pat[rk[4:0]] : 1'b1;
      rk++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; busy_1 = 1'b0; busy_3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Raises rd_busy on one instance and waits (bounded) for its done pulse.
  task automatic run_buf(input bit use3, input logic [15:0] len, input int budget,
                         input bit keep_busy, output int start_cyc, output bit timed_out);
    @(posedge clk); #1;
    dpram_len = len;
    if (use3) busy_3 = 1'b1; else busy_1 = 1'b1;
    start_cyc = cyc;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (use3 ? done_3 : done_1) begin timed_out = 1'b0; break; end
    end
    @(posedge clk); #1;
    if (!keep_busy) begin busy_1 = 1'b0; busy_3 = 1'b0; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rd_addr_1 !== 9'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr_1); end
    checks++; if (done_1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done_1); end
    checks++; if (m_valid_1 !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b want 0", m_valid_1); end
    checks++; if (m_last_1 !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %0b want 0", m_last_1); end
    checks++; if (m_data_1 !== 16'd0) begin errors++; $display("FAIL reset_m_data: got %h want 0", m_data_1); end
    checks++; if (n_bufs_1 !== 32'd0) begin errors++; $display("FAIL reset_n_bufs: got %0d want 0", n_bufs_1); end
    checks++; if (len_err_1 !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %0b want 0", len_err_1); end
    checks++; if (m_valid_3 !== 1'b0) begin errors++; $display("FAIL reset_m_valid_lat3: got %0b want 0", m_valid_3); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int st, n, d0; bit to;
    q_1.delete(); ready_mode = 1'b0; d0 = done_cnt_1;
    run_buf(1'b0, 16'd8, 60, 1'b0, st, to);
    n = q_1.size();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: done not seen"); end
    checks++; if (n != 8) begin errors++; $display("FAIL basic_count: got %0d want 8", n); end
    checks++; if (!(n > 0 && q_1[0].cyc - st <= 3)) begin errors++; $display("FAIL basic_latency: got %0d want <=3", (n > 0) ? q_1[0].cyc - st : -1); end
    for (int i = 0; i < n; i++) begin
      checks++; if (q_1[i].data !== 16'(i)) begin errors++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, q_1[i].data, i); end
      checks++; if (q_1[i].last !== (i == 7)) begin errors++; $display("FAIL basic_last[%0d]: got %0b want %0b", i, q_1[i].last, i == 7); end
      checks++; if (q_1[i].cyc != q_1[0].cyc + i) begin errors++; $display("FAIL basic_bubble[%0d]: cycle %0d want %0d", i, q_1[i].cyc, q_1[0].cyc + i); end
    end
    checks++; if (done_cyc_1 != ((n > 0) ? q_1[n-1].cyc + 1 : -1)) begin errors++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc_1, (n > 0) ? q_1[n-1].cyc + 1 : -1); end
    checks++; if (done_cnt_1 - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt_1 - d0); end
    checks++; if (n_bufs_1 !== 32'd1) begin errors++; $display("FAIL basic_n_bufs: got %0d want 1", n_bufs_1); end
    checks++; if (len_err_1 !== 1'b0) begin errors++; $display("FAIL basic_len_err: got %0b want 0", len_err_1); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_partial();
    int st, n, h0, d0; bit to;
    q_1.delete(); h0 = addr2_hits_1; d0 = done_cnt_1;
    run_buf(1'b0, 16'd6, 60, 1'b0, st, to);
    n = q_1.size();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL partial_timeout: done not seen"); end
    checks++; if (n != 6) begin errors++; $display("FAIL partial_count: got %0d want 6", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (q_1[i].data !== 16'(i) || q_1[i].last !== (i == 5)) begin
        errors++; $display("FAIL partial_beat[%0d]: got %0d/%0b want %0d/%0b", i, q_1[i].data, q_1[i].last, i, i == 5); end
    end
    checks++; if (addr2_hits_1 != h0) begin errors++; $display("FAIL partial_addr2: read %0d times want 0", addr2_hits_1 - h0); end
    checks++; if (done_cnt_1 - d0 != 1) begin errors++; $display("FAIL partial_done_count: got %0d want 1", done_cnt_1 - d0); end
    checks++; if (n_bufs_1 !== 32'd2) begin errors++; $display("FAIL partial_n_bufs: got %0d want 2", n_bufs_1); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_zero_len();
    int st; bit to;
    q_1.delete();
    run_buf(1'b0, 16'd0, 10, 1'b0, st, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL zero_timeout: done not seen"); end
    checks++; if (q_1.size() != 0) begin errors++; $display("FAIL zero_no_valid: got %0d beats want 0", q_1.size()); end
    checks++; if (done_cyc_1 - st > 3) begin errors++; $display("FAIL zero_done_latency: got %0d want <=3", done_cyc_1 - st); end
    checks++; if (n_bufs_1 !== 32'd3) begin errors++; $display("FAIL zero_n_bufs: got %0d want 3", n_bufs_1); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_en_block();
    int d0;
    q_1.delete(); d0 = done_cnt_1;
    @(posedge clk); #1;
    en = 1'b0; dpram_len = 16'd4; busy_1 = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (q_1.size() != 0) begin errors++; $display("FAIL en_block_beats: got %0d want 0", q_1.size()); end
    checks++; if (done_cnt_1 != d0) begin errors++; $display("FAIL en_block_done: got %0d pulses want 0", done_cnt_1 - d0); end
    @(posedge clk); #1;
    busy_1 = 1'b0; en = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_stall_lat3();
    int st, n, s0; bit to;
    q_3.delete(); ready_mode = 1'b0;
    run_buf(1'b1, 16'd8, 60, 1'b0, st, to);
    n = q_3.size();
    checks++; if (to !== 1'b0 || n != 8) begin errors++; $display("FAIL lat3_run: timeout=%0b beats %0d want 0/8", to, n); end
    checks++; if (!(n > 0 && q_3[0].cyc - st <= 5)) begin errors++; $display("FAIL lat3_latency: got %0d want <=5", (n > 0) ? q_3[0].cyc - st : -1); end
    checks++; if (!(n == 8 && q_3[7].cyc - q_3[0].cyc == 7)) begin errors++; $display("FAIL lat3_bubble: span %0d want 7", (n > 0) ? q_3[n-1].cyc - q_3[0].cyc : -1); end
    repeat (4) @(posedge clk);
    q_3.delete(); s0 = stall_err_3; ready_mode = 1'b1;
    run_buf(1'b1, 16'd16, 200, 1'b0, st, to);
    ready_mode = 1'b0;
    n = q_3.size();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout: done not seen"); end
    checks++; if (n != 16) begin errors++; $display("FAIL stall_count: got %0d want 16", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (q_3[i].data !== 16'(i) || q_3[i].last !== (i == 15)) begin
        errors++; $display("FAIL stall_beat[%0d]: got %0d/%0b want %0d/%0b", i, q_3[i].data, q_3[i].last, i, i == 15); end
    end
    checks++; if (stall_err_3 != s0) begin errors++; $display("FAIL stall_stable: %0d changes under stall want 0", stall_err_3 - s0); end
    checks++; if (n_bufs_3 !== 32'd2) begin errors++; $display("FAIL stall_n_bufs: got %0d want 2", n_bufs_3); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_clamp();
    int st, n, bad; bit to;
    q_1.delete(); bad = 0;
    run_buf(1'b0, 16'd3000, 2600, 1'b0, st, to);
    n = q_1.size();
    for (int i = 0; i < n; i++)
      if (q_1[i].data !== 16'(i) || q_1[i].last !== (i == 2047)) bad++;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL clamp_timeout: done not seen"); end
    checks++; if (n != 2048) begin errors++; $display("FAIL clamp_count: got %0d want 2048", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL clamp_data: %0d bad beats want 0", bad); end
    checks++; if (!(n > 0 && q_1[n-1].cyc - q_1[0].cyc == n - 1)) begin errors++; $display("FAIL clamp_bubble: span %0d want %0d", (n > 0) ? q_1[n-1].cyc - q_1[0].cyc : -1, n - 1); end
    checks++; if (len_err_1 !== 1'b1) begin errors++; $display("FAIL clamp_len_err: got %0b want 1", len_err_1); end
    checks++; if (rd_addr_1 !== 9'd511) begin errors++; $display("FAIL clamp_last_addr: got %0d want 511", rd_addr_1); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int st, n, d0, f1, gap; bit to1, to2;
    do_reset();
    q_1.delete(); d0 = done_cnt_1;
    run_buf(1'b0, 16'd5, 60, 1'b1, st, to1);
    f1 = done_cyc_1;
    to2 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_1) begin to2 = 1'b0; break; end
    end
    @(posedge clk); #1 busy_1 = 1'b0;
    n = q_1.size();
    gap = (n > 5) ? q_1[5].cyc - f1 : -1;
    checks++; if (to1 !== 1'b0 || to2 !== 1'b0) begin errors++; $display("FAIL b2b_timeout: %0b/%0b want 0/0", to1, to2); end
    checks++; if (n != 10) begin errors++; $display("FAIL b2b_count: got %0d want 10", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (q_1[i].data !== 16'(i % 5) || q_1[i].last !== (i % 5 == 4)) begin
        errors++; $display("FAIL b2b_beat[%0d]: got %0d/%0b want %0d/%0b", i, q_1[i].data, q_1[i].last, i % 5, i % 5 == 4); end
    end
    checks++; if (gap < HOLDOFF + 2 || gap > HOLDOFF + 4) begin errors++; $display("FAIL b2b_holdoff_gap: got %0d want %0d..%0d", gap, HOLDOFF + 2, HOLDOFF + 4); end
    checks++; if (done_cnt_1 - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt_1 - d0); end
    checks++; if (n_bufs_1 !== 32'd2) begin errors++; $display("FAIL b2b_n_bufs: got %0d want 2", n_bufs_1); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int d0, nq; bit reached;
    q_1.delete();
    @(posedge clk); #1;
    dpram_len = 16'd40; busy_1 = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q_1.size() >= 5) begin reached = 1'b1; break; end
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("FAIL rstmid_stream: got %0d beats want >=5", q_1.size()); end
    @(posedge clk); #1;
    rst = 1'b1; busy_1 = 1'b0; d0 = done_cnt_1; nq = q_1.size();
    @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid_1 !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid: got %0b want 0", m_valid_1); end
    checks++; if (m_last_1 !== 1'b0) begin errors++; $display("FAIL rstmid_m_last: got %0b want 0", m_last_1); end
    checks++; if (m_data_1 !== 16'd0) begin errors++; $display("FAIL rstmid_m_data: got %h want 0", m_data_1); end
    checks++; if (rd_addr_1 !== 9'd0) begin errors++; $display("FAIL rstmid_rd_addr: got %0d want 0", rd_addr_1); end
    checks++; if (n_bufs_1 !== 32'd0) begin errors++; $display("FAIL rstmid_n_bufs: got %0d want 0", n_bufs_1); end
    checks++; if (done_1 !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %0b want 0", done_1); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (done_cnt_1 != d0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt_1 - d0); end
    checks++; if (q_1.size() != nq) begin errors++; $display("FAIL rstmid_no_beats: got %0d extra want 0", q_1.size() - nq); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; busy_1 = 1'b0; busy_3 = 1'b0; dpram_len = '0;
    test_reset();
    test_basic();
    test_partial();
    test_zero_len();
    test_en_block();
    test_stall_lat3();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
